// File: rtl/bcd_calc_ctrl.sv
// Keypad front-end and sequencer for a 4-digit BCD calculator: edge-detects key presses,
// builds operands, drives an external BCD add/subtract unit and keeps the accumulator.
module bcd_calc_ctrl #(
    parameter int MAX_DIGITS = 4
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic        key_in,
    input  logic [4:0]  key_code,
    input  logic [15:0] add_s,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_op,
    output logic [15:0] disp,
    output logic [1:0]  state
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        ENTRY1 = 2'd0,
        OPER   = 2'd1,
        ENTRY2 = 2'd2,
        RESULT = 2'd3
    } st_t;

    st_t              st_q, st_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             key_q;

    logic             press;
    logic [3:0]       digit;
    logic             is_digit;
    logic             cnt_room;

    // A press is the rising edge of key_in; holding the key never repeats.
    assign press    = key_in & ~key_q;
    assign digit    = key_code[3:0];
    assign is_digit = (key_code <= 5'd9);
    assign cnt_room = (cnt_q < CNT_W'(MAX_DIGITS));

    always_comb begin
        acc_d = acc_q;
        cur_d = cur_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        st_d  = st_q;
        if (press) begin
            if (is_digit) begin
                case (st_q)
                    ENTRY1, ENTRY2: begin
                        if (cnt_room) begin
                            cur_d = {cur_q[11:0], digit};
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    OPER: begin
                        cur_d = {12'h000, digit};
                        cnt_d = CNT_W'(1);
                        st_d  = ENTRY2;
                    end
                    RESULT: begin
                        cur_d = {12'h000, digit};
                        cnt_d = CNT_W'(1);
                        acc_d = 16'h0000;
                        st_d  = ENTRY1;
                    end
                endcase
            end else begin
                case (key_code)
                    5'd16, 5'd17: begin
                        op_d = key_code[0];
                        case (st_q)
                            ENTRY1: begin
                                acc_d = cur_q;
                                st_d  = OPER;
                            end
                            // Chained operation folds the pending result into acc.
                            ENTRY2: begin
                                acc_d = add_s;
                                st_d  = OPER;
                            end
                            OPER:   ;
                            RESULT: st_d = OPER;
                        endcase
                    end
                    5'd18: begin
                        if (st_q == ENTRY2) begin
                            acc_d = add_s;
                            st_d  = RESULT;
                        end
                    end
                    5'd19: begin
                        acc_d = 16'h0000;
                        cur_d = 16'h0000;
                        cnt_d = '0;
                        op_d  = 1'b0;
                        st_d  = ENTRY1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            key_q <= 1'b0;
            acc_q <= 16'h0000;
            cur_q <= 16'h0000;
            cnt_q <= '0;
            op_q  <= 1'b0;
            st_q  <= ENTRY1;
        end else begin
            key_q <= key_in;
            acc_q <= acc_d;
            cur_q <= cur_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
            st_q  <= st_d;
        end
    end

    assign add_a  = acc_q;
    assign add_b  = cur_q;
    assign add_op = op_q;
    assign state  = st_q;
    assign disp   = ((st_q == ENTRY1) || (st_q == ENTRY2)) ? cur_q : acc_q;

endmodule
